// File: rtl/xor_chain.sv
// ---------------------------------------------------------------------------
// xor_chain
//   Handshaked word-XOR recurrence engine for key expansion.
//   Computes w[i] = op[i] ^ w[i-DEPTH], where op[i] is either the external
//   operand on in_word or the previous result w[i-1] (in_chain = 1).
//   The first DEPTH words of a run are seeds and pass straight through.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   start                 begin or restart a run (aborts any run in flight)
//   in_valid / in_ready   input handshake; in_ready is combinational
//   in_word               seed word (LOAD) or external operand (RUN)
//   in_chain              RUN only: use previous result instead of in_word
//   out_valid / out_ready output handshake
//   out_word              result word w[i]
//   busy                  high while a run is in LOAD or RUN
//   done                  one-cycle pulse on acceptance of word TOTAL-1
// ---------------------------------------------------------------------------
module xor_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TOTAL = 44
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST_SEED = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // hist[0] is w[cnt-DEPTH] (oldest), hist[DEPTH-1] is w[cnt-1] (newest)
    logic [WIDTH-1:0] hist [DEPTH];

    logic             accept;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] result;

    // Accept only in an active run, never alongside start, and only when the
    // output register is empty or being drained this cycle.
    assign in_ready = (state != IDLE) && !start && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Result of the word being accepted: seeds pass through, RUN words XOR
    // their operand with the word DEPTH positions back.
    always_comb begin
        operand = in_chain ? hist[DEPTH-1] : in_word;
        result  = in_word;
        if (state == RUN) begin
            result = operand ^ hist[0];
        end
    end

    // Control FSM, word counter, history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                hist[i] <= '0;
            end
            out_valid <= 1'b0;
            out_word  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // Abort/restart: pending output is dropped; hist is
                // fully rewritten by the coming seeds so it is left as is.
                state     <= LOAD;
                cnt       <= '0;
                out_valid <= 1'b0;
                busy      <= 1'b1;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    out_word  <= result;
                    out_valid <= 1'b1;
                    cnt       <= cnt + CNT_W'(1);
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        hist[i] <= hist[i+1];
                    end
                    hist[DEPTH-1] <= result;
                    case (state)
                        LOAD: begin
                            if (cnt == LAST_SEED) begin
                                state <= RUN;
                            end
                        end
                        RUN: begin
                            if (cnt == LAST_WORD) begin
                                state <= IDLE;
                                cnt   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_chain.sv
// ---------------------------------------------------------------------------
// tb_xor_chain
//   Self-checking bench for xor_chain (WIDTH=32, DEPTH=4, TOTAL=44).
//   Accepted inputs push the expected result into a scoreboard queue; a
//   negedge monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_xor_chain;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TOTAL = 44;

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             in_chain;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic             busy;
    logic             done;

    xor_chain #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .TOTAL(TOTAL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .in_chain (in_chain),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             chain;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t             aes_tab [8];
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] hw [TOTAL];
    int               mcnt;
    int               n_checks;
    int               n_fail;
    int               n_done;
    bit               rand_ready;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer and done-pulse counter.
    always @(negedge clk) begin
        if (!rst && done) n_done++;
        if (!rst && !start && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got %h, required no output", out_word);
            end else begin
                logic [WIDTH-1:0] e;
                e = sb.pop_front();
                if (out_word !== e) begin
                    n_fail++;
                    $display("FAIL out_word: got %h, required %h", out_word, e);
                end
            end
        end
    end

    // Offer one word until accepted; push its expected result on acceptance.
    task automatic send(input logic [WIDTH-1:0] w, input logic ch,
                        input bit use_exp, input logic [WIDTH-1:0] e);
        logic [WIDTH-1:0] m;
        bit ok;
        ok       = 1'b0;
        in_word  = w;
        in_chain = ch;
        in_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) begin
                if (mcnt < int'(DEPTH)) m = w;
                else m = (ch ? hw[mcnt-1] : w) ^ hw[mcnt-int'(DEPTH)];
                hw[mcnt] = m;
                sb.push_back(use_exp ? e : m);
                mcnt++;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else if (mcnt == int'(TOTAL)) begin
            check("done_on_last", 32'(done), 32'd1);
            check("busy_after_last", 32'(busy), 32'd0);
            mcnt = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // start (optionally with a word offered): must not accept, clears output.
    task automatic do_start(input logic iv);
        start    = 1'b1;
        in_valid = iv;
        @(negedge clk);
        check("start_blocks_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        check("start_clears_out_valid", 32'(out_valid), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        sb.delete();
        mcnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        aes_tab[0] = '{32'h2b7e1516, 1'b0, 32'h2b7e1516};
        aes_tab[1] = '{32'h28aed2a6, 1'b0, 32'h28aed2a6};
        aes_tab[2] = '{32'habf71588, 1'b0, 32'habf71588};
        aes_tab[3] = '{32'h09cf4f3c, 1'b0, 32'h09cf4f3c};
        aes_tab[4] = '{32'h8b84eb01, 1'b0, 32'ha0fafe17};
        aes_tab[5] = '{32'h00000000, 1'b1, 32'h88542cb1};
        aes_tab[6] = '{32'hffffffff, 1'b1, 32'h23a33939};
        aes_tab[7] = '{32'h5a5a5a5a, 1'b1, 32'h2a6c7605};

        n_checks = 0; n_fail = 0; n_done = 0; mcnt = 0; rand_ready = 1'b0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_word = '0;
        in_chain = 1'b0; out_ready = 1'b1;

        // Reset values, with a word offered in IDLE.
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // AES-128 seeds and first recurrence words.
        do_start(1'b0);
        for (int i = 0; i < 8; i++) send(aes_tab[i].word, aes_tab[i].chain, 1'b1, aes_tab[i].exp);

        // Backpressure: one word accepted, then 3 stalled cycles.
        idle_cycles(1);
        out_ready = 1'b0;
        send(32'h12345678, 1'b0, 1'b0, '0);
        in_word = 32'h0badf00d; in_chain = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_word", out_word, hw[mcnt-1]);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n = int'(TOTAL) - mcnt;
        for (int i = 0; i < n; i++) send($urandom, 1'($urandom_range(0, 1)), 1'b0, '0);

        // After the run: final result drains, nothing accepted in IDLE.
        in_valid = 1'b1;
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_in_ready", 32'(in_ready), 32'd0);
        check("end_out_pending", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        check("end_drained", 32'(out_valid), 32'd0);
        check("end_done_low", 32'(done), 32'd0);
        in_valid = 1'b0;

        // Second full run under random output backpressure.
        do_start(1'b0);
        rand_ready = 1'b1;
        for (int i = 0; i < int'(TOTAL); i++) send($urandom, 1'($urandom_range(0, 1)), 1'b0, '0);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle_cycles(3);
        check("run2_sb_empty", 32'(sb.size()), 32'd0);

        // Abort at cnt = 6 with a pending output and a word offered.
        do_start(1'b0);
        for (int i = 0; i < 6; i++) send($urandom, 1'b0, 1'b0, '0);
        out_ready = 1'b0;
        in_word   = 32'hdeadbeef;
        do_start(1'b1);
        out_ready = 1'b1;
        send(32'hcafef00d, 1'b1, 1'b1, 32'hcafef00d);
        check("abort_seed0", out_word, 32'hcafef00d);
        for (int i = 0; i < 4; i++) send($urandom, 1'b0, 1'b0, '0);

        // Async reset mid-RUN with a pending output.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        mcnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_start(1'b0);
        for (int i = 0; i < 5; i++) send(aes_tab[i].word, aes_tab[i].chain, 1'b1, aes_tab[i].exp);
        check("arst_w4", out_word, 32'ha0fafe17);
        idle_cycles(2);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("done_pulse_count", 32'(n_done), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_chain.md
# xor_chain

Parametrised, handshaked word-XOR recurrence engine for the key-expansion datapath. It computes w[i] = op[i] ^ w[i-DEPTH] over a stream of WIDTH-bit words. The operand op[i] is either an externally supplied word (the SubWord/RotWord/Rcon-transformed temp) or the block's own previous result w[i-1]. It replaces the single combinational 32-bit XOR with a stateful unit that holds the DEPTH-word history, counts words, and emits a completion pulse. It sits between the temp-transform stage and the round-key store.

## Interface
- WIDTH, 32, word width in bits.
- DEPTH, 4, recurrence distance Nk (4/6/8 for AES-128/192/256); must be ≥ 1.
- TOTAL, 44, total words produced per run, seeds included; must be > DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin (or restart) a run.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_word  in  WIDTH  seed word (LOAD) or external operand (RUN).
- in_chain  in  1  RUN only: 1 = use previous result as operand and ignore in_word.
- out_valid  out  1  out_word holds a result.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_word  out  WIDTH  result word w[i].
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse, registered with acceptance of word TOTAL-1.

## Operation
- States:
  - IDLE → LOAD on start.
  - LOAD → RUN after DEPTH accepted words.
  - RUN → IDLE after the word with index TOTAL-1 is accepted.
- Word index cnt counts 0..TOTAL-1 and increments on each accepted input.
- History: a DEPTH-entry shift register hist. hist[0] is the oldest entry, w[cnt-DEPTH]; hist[DEPTH-1] is the newest, w[cnt-1]. Each accepted word's result shifts in at the newest end.
- LOAD: result = in_word (pass-through seed). in_chain is ignored.
- RUN: result = (in_chain ? hist[DEPTH-1] : in_word) ^ hist[0]. Plain bitwise XOR; no carries, full WIDTH.
- start in LOAD or RUN aborts the run:
  - returns to LOAD with cnt = 0;
  - clears out_valid, so any pending output is discarded;
  - leaves hist contents don't-care (all of hist is overwritten during LOAD).
- start in IDLE while out_valid is high: out_valid is cleared in the same way.
- Input words offered in IDLE are never accepted.

## Timing
- Reset values: state IDLE, cnt 0, hist all 0, out_valid 0, out_word 0, busy 0, done 0, in_ready 0.
- in_ready = (state is LOAD or RUN) && !start && (!out_valid || out_ready). This is combinational from registered state and the start/out_ready inputs.
- Latency: a word accepted at edge k appears on out_word with out_valid = 1 after edge k. Throughput is one word per cycle while out_ready is held high.
- out_valid and out_word are held stable while out_valid && !out_ready.
- Output transfer and a new input acceptance in the same cycle: out_word is replaced by the new result and out_valid stays 1.
- Simultaneous start and in_valid: start wins and the word is not accepted.
- done rises on the edge that accepts word TOTAL-1, with the state entering IDLE. It is high for exactly one cycle, and the final result is still pending on the output.
- busy falls on the same edge. The last result drains through the output register after busy = 0.
- Asynchronous rst mid-run forces all reset values immediately. Any pending output is lost.

## Test plan
- AES-128 seeds (DEPTH=4): start, then in_word = 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c with in_chain = 0. Required: the same four words on out_word at 1-cycle latency; state enters RUN.
- After the seeds, send in_word = 0x8b84eb01 with in_chain = 0, then three words with in_chain = 1. Required outputs: 0xa0fafe17, 0x88542cb1, 0x23a33939, 0x2a6c7605.
- Backpressure: hold out_ready = 0 for 3 cycles mid-RUN. Required: in_ready = 0 after one accepted word, out_word stable, no word lost or duplicated after release.
- Full run with TOTAL=44: stream 44 words with out_ready = 1. Required: done pulses once on the 44th acceptance, busy = 0 afterwards, in_ready = 0 in IDLE.
- start asserted at cnt = 6 with in_valid = 1 and a pending output. Required: word not accepted, out_valid cleared, next accepted word treated as seed 0 (pass-through).
- Async rst asserted between clock edges mid-RUN. Required: out_valid, busy and in_ready drop to 0 immediately; after release a fresh run reproduces 0xa0fafe17 at word 4.
